// File: rtl/mem_bus_arbiter.sv
// Two-master request/acknowledge arbiter for the shared data-memory/IO bus.
// Round-robin or fixed m0 priority; one transaction at a time through ISSUE/WAIT/ACK.
module mem_bus_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t      r_state, w_next;
  logic        r_id, r_we, r_last;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_cnt;
  logic        w_grant, w_gid;

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_gid   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          w_grant = 1'b1;
          w_gid   = FIXED_PRIO ? 1'b0 : ~r_last;
        end else if (m0_req) begin
          w_grant = 1'b1;
          w_gid   = 1'b0;
        end else if (m1_req) begin
          w_grant = 1'b1;
          w_gid   = 1'b1;
        end
        if (w_grant) w_next = S_ISSUE;
      end
      S_ISSUE: w_next = r_we ? S_ACK : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Bus address/data come straight from these latches, so they only move at a grant.
      if (w_grant) begin
        r_id    <= w_gid;
        r_we    <= w_gid ? m1_we    : m0_we;
        r_addr  <= w_gid ? m1_addr  : m0_addr;
        r_wdata <= w_gid ? m1_wdata : m0_wdata;
      end
      if (r_state == S_ISSUE && !r_we) r_cnt <= LAT;
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) r_rdata <= mem_rdata;
      end
      if (r_state == S_ACK) r_last <= r_id;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = (r_state == S_ISSUE) && r_we;
  assign m0_ack    = (r_state == S_ACK) && !r_id;
  assign m1_ack    = (r_state == S_ACK) &&  r_id;
  assign busy      = (r_state != S_IDLE);
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table plus reset, input-change and contention sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        a_m0_ack, a_m1_ack, a_mem_we, a_busy;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_m0_ack, b_m1_ack, b_mem_we, b_busy;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  // Round-robin, RD_LAT=1
  mem_bus_arbiter #(.RD_LAT(1), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(a_m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(a_m1_ack),
    .rdata(a_rdata), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy));

  // Fixed priority, RD_LAT=3
  mem_bus_arbiter #(.RD_LAT(3), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(b_m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(b_m1_ack),
    .rdata(b_rdata), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h20) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  assign a_mem_rdata = mem_word(a_mem_addr);
  assign b_mem_rdata = mem_word(b_mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r0, r1, we0, we1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  exp_ack;   // {m1_ack, m0_ack}
    int unsigned exp_lat;
    logic [31:0] exp_rdata;
    int unsigned exp_wecnt;
    logic [31:0] exp_waddr, exp_wdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int unsigned lat, wecnt, n0, nb0, nb1, tb0, tb1, cyc;
    logic [31:0] waddr, wdata;
    logic [1:0]  ackv;
    logic        order[6];

    // Round-robin starts with last_served=1, so m0 takes the first tie.
    vecs[0] = '{1,1, 1,0, 32'h104,32'h20, 32'h3FF,32'h0, 2'b01, 2, 32'h0,        1, 32'h104, 32'h3FF};
    vecs[1] = '{0,1, 0,0, 32'h0,  32'h20, 32'h0,  32'h0, 2'b10, 3, 32'hDEADBEEF, 0, 32'h0,   32'h0};
    vecs[2] = '{1,1, 0,0, 32'h40, 32'h44, 32'h0,  32'h0, 2'b01, 3, 32'hA5A50040, 0, 32'h0,   32'h0};
    vecs[3] = '{1,1, 1,1, 32'h80, 32'h84, 32'h11, 32'h22,2'b10, 2, 32'hA5A50040, 1, 32'h84,  32'h22};
    vecs[4] = '{1,0, 1,0, 32'hC0, 32'h0,  32'h55, 32'h0, 2'b01, 2, 32'hA5A50040, 1, 32'hC0,  32'h55};
    vecs[5] = '{1,1, 0,0, 32'h100,32'h200,32'h0,  32'h0, 2'b10, 3, 32'hA5A50200, 0, 32'h0,   32'h0};
    vecs[6] = '{0,1, 0,0, 32'h0,  32'h20, 32'h0,  32'h0, 2'b10, 3, 32'hDEADBEEF, 0, 32'h0,   32'h0};
    vecs[7] = '{1,1, 0,0, 32'h30, 32'h34, 32'h0,  32'h0, 2'b01, 3, 32'hA5A50030, 0, 32'h0,   32'h0};

    // Reset with both masters requesting
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h104; m0_wdata = 32'h3FF;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;  m1_wdata = 32'h0;
    tick(); tick();
    chk("reset_ctrl", {29'd0, a_busy, a_m1_ack, a_m0_ack}, 32'h0);
    chk("reset_we", {31'd0, a_mem_we}, 32'h0);
    chk("reset_addr", a_mem_addr, 32'h0);
    chk("reset_wdata", a_mem_wdata, 32'h0);
    chk("reset_rdata", a_rdata, 32'h0);
    m0_req = 1'b0; m1_req = 1'b0;
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      m0_req = vecs[i].r0; m0_we = vecs[i].we0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
      m1_req = vecs[i].r1; m1_we = vecs[i].we1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
      lat = 0; wecnt = 0; waddr = '0; wdata = '0; ackv = 2'b00;
      while (ackv == 2'b00 && lat < 20) begin
        tick();
        lat++;
        if (a_mem_we) begin wecnt++; waddr = a_mem_addr; wdata = a_mem_wdata; end
        ackv = {a_m1_ack, a_m0_ack};
      end
      chk($sformatf("v%0d_ack", i), {30'd0, ackv}, {30'd0, vecs[i].exp_ack});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_rdata", i), a_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_wecnt", i), wecnt, vecs[i].exp_wecnt);
      if (vecs[i].exp_wecnt != 0) begin
        chk($sformatf("v%0d_waddr", i), waddr, vecs[i].exp_waddr);
        chk($sformatf("v%0d_wdata", i), wdata, vecs[i].exp_wdata);
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tick();
      chk($sformatf("v%0d_idle", i), {29'd0, a_busy, a_m1_ack, a_m0_ack}, 32'h0);
    end

    // Reset during WAIT of an m1 read
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    tick();
    chk("mr_issue_busy", {31'd0, a_busy}, 32'h1);
    tick();
    chk("mr_wait_ctrl", {30'd0, a_busy, a_mem_we}, 32'h2);
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h60;
    tick();
    chk("mr_reset_ctrl", {29'd0, a_busy, a_m1_ack, a_m0_ack}, 32'h0);
    chk("mr_reset_rdata", a_rdata, 32'h0);
    chk("mr_reset_addr", a_mem_addr, 32'h0);
    reset = 1'b1;
    tick();
    chk("mr_grant_addr", a_mem_addr, 32'h60);
    cyc = 0;
    while (!(a_m0_ack || a_m1_ack) && cyc < 20) begin tick(); cyc++; end
    chk("mr_grant_ack", {30'd0, a_m1_ack, a_m0_ack}, 32'h1);
    chk("mr_grant_rdata", a_rdata, 32'hA5A50060);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // Inputs change after the grant (req also dropped early)
    reset = 1'b0; tick(); reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
    tick();
    m0_addr = 32'h10; m0_req = 1'b0; m0_we = 1'b1;
    chk("ic_issue_addr", a_mem_addr, 32'h8);
    tick();
    chk("ic_wait_addr", a_mem_addr, 32'h8);
    chk("ic_wait_we", {31'd0, a_mem_we}, 32'h0);
    tick();
    chk("ic_ack", {30'd0, a_m1_ack, a_m0_ack}, 32'h1);
    chk("ic_ack_addr", a_mem_addr, 32'h8);
    chk("ic_rdata", a_rdata, 32'hA5A50008);
    tick();

    // Continuous contention on both instances
    reset = 1'b0; tick(); reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hC;
    n0 = 0; nb0 = 0; nb1 = 0; tb0 = 0; tb1 = 0; cyc = 0;
    while ((n0 < 6 || nb0 < 6) && cyc < 200) begin
      tick();
      cyc++;
      if ((a_m0_ack || a_m1_ack) && n0 < 6) begin order[n0] = a_m1_ack; n0++; end
      if (b_m0_ack) begin
        nb0++;
        if (nb0 == 1) tb0 = cyc;
        if (nb0 == 2) tb1 = cyc;
      end
      if (b_m1_ack) nb1++;
    end
    chk("rr_count", n0, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), {31'd0, order[i]}, (i % 2 == 1) ? 32'h1 : 32'h0);
    chk("fp_m0_count", nb0, 6);
    chk("fp_m1_count", nb1, 0);
    chk("fp_period", tb1 - tb0, 6);
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data-memory/IO bus port between two requesters: m0 (riscvmulti CPU) and m1 (a second bus master, e.g. a DMA or debug loader).
- Sits between the masters and the existing RAM/IO decode. Its mem_* outputs drive the addr/writedata/memwrite nets that feed mem and the I/O registers.
- Serialises accesses with a request/acknowledge handshake. Arbitration is round-robin, or fixed priority to m0.

Parameters:
- RD_LAT, 1, memory read latency in clk cycles (1..7); mem_rdata is valid RD_LAT cycles after the ISSUE cycle.
- FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins a simultaneous request.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset).
- m0_req  input  1  m0 access request; level, held until m0_ack.
- m0_we  input  1  m0 write enable (1 = write, 0 = read).
- m0_addr  input  32  m0 byte address.
- m0_wdata  input  32  m0 write data.
- m0_ack  output  1  one-cycle completion pulse to m0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack  same as m0, for m1.
- rdata  output  32  read data for the master being acked; shared by both masters.
- mem_we  output  1  write strobe to the memory/IO bus.
- mem_addr  output  32  bus address.
- mem_wdata  output  32  bus write data.
- mem_rdata  input  32  bus read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset, sampled on a clk edge with reset=0:
  - state=IDLE; m0_ack=m1_ack=0; mem_we=0; mem_addr=0; mem_wdata=0; rdata=0; busy=0.
  - last_served=1, so m0 wins the first tie.
  - Reset overrides any in-flight transaction: no ack is issued and mem_we is 0 from the next cycle on.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that master.
  - Both req:
    - FIXED_PRIO=1: grant m0.
    - FIXED_PRIO=0: grant the master != last_served.
  - On grant: latch id, we, addr, wdata into internal registers, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr/mem_wdata come from the latched registers.
  - mem_we = latched we, for this cycle only.
  - Next state: ACK if write; WAIT with counter=RD_LAT if read.
- WAIT (RD_LAT cycles):
  - mem_addr held stable, mem_we=0, counter decrements each cycle.
  - On the edge where counter==1: capture mem_rdata into rdata, go to ACK.
- ACK (1 cycle):
  - The granted master's ack=1, the other ack=0.
  - Set last_served = granted id, go to IDLE.
- Latency from req first seen in IDLE to ack high:
  - Write: 2 cycles.
  - Read: 2+RD_LAT cycles.
  - Idle gap between back-to-back transactions: 1 cycle.
- rdata:
  - Updated only on read completions; holds its value through later writes and idle cycles.
  - Valid while the read ack is high and afterwards.
- Bus outputs:
  - mem_addr/mem_wdata retain their last value in IDLE and ACK; no glitches.
  - mem_we is high only in ISSUE of a write.
- Inputs are sampled only at the IDLE grant edge. Changes to m*_addr/we/wdata/req during ISSUE, WAIT or ACK have no effect on the current transaction.
- A req still high in the IDLE cycle after its ack is a new request. Masters must drop req the cycle after ack to avoid a repeat access.
- If req drops before ack (protocol violation), the transaction still completes and ack still pulses.
- Round-robin guarantees that, with both masters requesting continuously, grants strictly alternate m0, m1, m0, …
- busy=1 in ISSUE, WAIT and ACK.

Test Plan:
- Reset: hold reset=0 for 2 cycles with both req=1 → all outputs 0, state IDLE. After release, the first grant is m0 and mem_addr = m0_addr.
- Single write: m0 writes addr=0x104, wdata=0x3FF → mem_we=1 for exactly 1 cycle with mem_addr=0x104 and mem_wdata=0x3FF. m0_ack is high 2 cycles after the grant edge; m1_ack stays 0.
- Single read, RD_LAT=1: m1 reads 0x20 while the memory model returns 0xDEADBEEF → m1_ack=1 and rdata=0xDEADBEEF 3 cycles after the grant edge; mem_we stays 0 throughout.
- Contention, FIXED_PRIO=0: both masters read continuously for 6 transactions → ack order m0, m1, m0, m1, m0, m1. With FIXED_PRIO=1 → six m0 acks and no m1_ack.
- Mid-operation reset: assert reset=0 during WAIT of an m1 read → no m1_ack, busy=0 next cycle, rdata=0. After release, a pending m0 request is granted first.
- Input change after grant: m0 read at 0x8; change m0_addr to 0x10 during WAIT → mem_addr stays 0x8 until ACK; rdata reflects the word at 0x8.
